re_requester: RTL and testbench

Synchronous four-phase initiator for the REreq/REack channel of the v2 stage controller. It queues start requests from clocked logic and drives REreq. It waits for the controller's asynchronous REack through a synchronizer and reports each completed handshake with a one-cycle `done` pulse. It sits on the clocked side of the boundary, opposite the REack generator.

---
 rtl/re_requester_if.sv | 38 +++
 rtl/re_requester.sv | 221 ++++++++++++++++++++++
 tb/tb_re_requester.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/re_requester_if.sv
// re_requester_if: groups the request/acknowledge channel and the status
// outputs of the REreq/REack initiator.
//   master : the requester side (drives REreq and the status outputs)
//   slave  : the surrounding logic/controller side (drives start and REack)
interface re_requester_if #(
    parameter int PEND_W = 4
);
    logic              start;     // one-cycle request for one handshake
    logic              REack;     // asynchronous acknowledge from the stage controller
    logic              REreq;     // registered request to the stage controller
    logic              busy;      // FSM not idle or requests still queued
    logic              done;      // one-cycle pulse per completed handshake
    logic              ovf;       // one-cycle pulse when a start is dropped at saturation
    logic [PEND_W-1:0] pend_cnt;  // requests accepted but not yet started
    logic              timeout;   // one-cycle pulse on watchdog expiry

    modport master (
        input  start,
        input  REack,
        output REreq,
        output busy,
        output done,
        output ovf,
        output pend_cnt,
        output timeout
    );

    modport slave (
        output start,
        output REack,
        input  REreq,
        input  busy,
        input  done,
        input  ovf,
        input  pend_cnt,
        input  timeout
    );
endinterface

// File: rtl/re_requester.sv
// re_requester: synchronous four-phase initiator for the REreq/REack channel.
// Queues start requests in a saturating counter, drives a registered REreq,
// observes REack through a SYNC_STAGES-deep synchronizer and pulses done once
// per completed handshake. Back-to-back handshakes re-raise REreq on the same
// edge that done asserts.
//
// Optional feature macro: RE_REQUESTER_TIMEOUT_EN
//   Defined   : per-phase watchdog of TO_CYCLES clocks; on expiry pulses
//               timeout, flushes the queue and parks in ABORT until REack
//               is seen low.
//   Undefined : handshakes wait indefinitely, timeout is tied low.
module re_requester #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 4,
    parameter int TO_CYCLES   = 255
) (
    input logic            clk,
    input logic            rst,
    re_requester_if.master bus
);

    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    // Elaboration-time guard against parameter values the logic cannot support.
    generate
        if (SYNC_STAGES < 2 || PEND_W < 1 || TO_CYCLES < 1) begin : g_param_check
            $error("re_requester: SYNC_STAGES must be >= 2, PEND_W and TO_CYCLES >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
`ifdef RE_REQUESTER_TIMEOUT_EN
        REQ_LO = 2'd2,
        ABORT  = 2'd3
`else
        REQ_LO = 2'd2
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Acknowledge synchronizer: the only consumer of raw REack.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;

    // Shift REack through SYNC_STAGES flops; cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples
        // the pre-edge value of its neighbours regardless of statement order.
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.REack};
        end
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State and pending-request registers
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              pend_nz;
    logic              consume;    // a request is taken this cycle (entry to REQ_HI)
    logic              direct;     // the request taken is this cycle's start
    logic              start_ok;   // start is eligible to be queued this cycle
    logic              inc, dec;
    logic              flush;      // watchdog discards the queue
    logic              done_d;
    logic              ovf_d;

    logic              req_q;
    logic              busy_q;
    logic              done_q;
    logic              ovf_q;

    assign pend_nz = |pend_q;

`ifdef RE_REQUESTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] phase_q;
    logic            timeout_d;
    logic            timeout_q;
`endif

    // Next-state, queue bookkeeping and pulse generation.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        consume  = 1'b0;
        done_d   = 1'b0;
        flush    = 1'b0;
        start_ok = bus.start;
`ifdef RE_REQUESTER_TIMEOUT_EN
        timeout_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                // Gated by ack_s=0 so a controller still finishing a
                // return-to-zero (e.g. after reset) is never re-requested.
                if (!ack_s && (pend_nz || bus.start)) begin
                    state_d = REQ_HI;
                    consume = 1'b1;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    done_d = 1'b1;
                    if (pend_nz || bus.start) begin
                        state_d = REQ_HI;
                        consume = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef RE_REQUESTER_TIMEOUT_EN
            ABORT: begin
                // Requests arriving while aborting are dropped silently.
                start_ok = 1'b0;
                if (!ack_s) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef RE_REQUESTER_TIMEOUT_EN
        // Watchdog: a phase that would reach TO_CYCLES clocks without a
        // transition is abandoned instead.
        if ((state_q == REQ_HI || state_q == REQ_LO) && (state_d == state_q) &&
            (phase_q == TO_W'(TO_CYCLES - 1))) begin
            state_d   = ABORT;
            timeout_d = 1'b1;
            flush     = 1'b1;
            start_ok  = 1'b0;
        end
`endif

        // A start consumed in its own cycle (queue empty) bypasses the counter.
        direct = consume && !pend_nz;
        inc    = start_ok && !direct;
        dec    = consume && pend_nz;

        pend_d = pend_q;
        ovf_d  = 1'b0;
        if (flush) begin
            pend_d = '0;
        end else if (inc && !dec) begin
            if (pend_q == PEND_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + 1'b1;
            end
        end else if (dec && !inc) begin
            pend_d = pend_q - 1'b1;
        end
    end

    // State register and registered outputs, all reflecting the post-edge state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            req_q   <= (state_d == REQ_HI);
            busy_q  <= (state_d != IDLE) || (pend_d != '0);
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef RE_REQUESTER_TIMEOUT_EN
    // Phase counter: restarts on every state change, counts while a
    // handshake phase is outstanding; also registers the timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
            if (state_d != state_q) begin
                phase_q <= '0;
            end else if (state_q == REQ_HI || state_q == REQ_LO) begin
                phase_q <= phase_q + 1'b1;
            end
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.REreq    = req_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ovf      = ovf_q;
    assign bus.pend_cnt = pend_q;

endmodule

// File: tb/tb_re_requester.sv
// tb_re_requester: directed bench for re_requester with a behavioural stage
// controller and a scoreboard of expected handshake completions.
// Build with +define+RE_REQUESTER_TIMEOUT_EN to exercise the watchdog path.
module tb_re_requester;

    localparam int SYNC_STAGES = 2;
    localparam int PEND_W      = 4;
    localparam int TO_CYCLES   = 16;
    localparam int PEND_MAX    = (1 << PEND_W) - 1;
    localparam int ACK_DLY     = 3;
    localparam int REL_DLY     = 3;
    localparam int WAIT_LIMIT  = 300;

    logic clk;
    logic rst;
    logic ctrl_en;

    int vectors;
    int miscompares;
    int rises;
    int done_cnt;
    int ovf_cnt;
    int sb_next_id;
    int exp_q[$];

    re_requester_if #(.PEND_W(PEND_W)) bus ();

    re_requester #(
        .SYNC_STAGES(SYNC_STAGES),
        .PEND_W     (PEND_W),
        .TO_CYCLES  (TO_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input int n);
        for (int i = 0; i < n; i++) begin
            sb_next_id++;
            exp_q.push_back(sb_next_id);
        end
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            tick();
            if (bus.done === 1'b1) break;
        end
        check(tag, 32'(bus.done), 32'd1);
    endtask

    task automatic wait_ack(input logic level, input string tag);
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            tick();
            if (bus.REack === level) break;
        end
        check(tag, 32'(bus.REack), 32'(level));
    endtask

    // Stage controller model: raises REack ACK_DLY clocks after REreq rises,
    // releases it REL_DLY clocks after REreq falls. Drives on the falling edge.
    initial begin : ctrl_model
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            if (!ctrl_en) begin
                c = 0;
            end else if (bus.REreq === 1'b1 && bus.REack === 1'b0) begin
                c++;
                if (c >= ACK_DLY) begin
                    bus.REack = 1'b1;
                    c = 0;
                end
            end else if (bus.REreq === 1'b0 && bus.REack === 1'b1) begin
                c++;
                if (c >= REL_DLY) begin
                    bus.REack = 1'b0;
                    c = 0;
                end
            end else begin
                c = 0;
            end
        end
    end

    // Output monitor: counts REreq rises, ovf pulses and retires scoreboard
    // entries on each done pulse.
    initial begin : monitor
        logic req_prev;
        int   e;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.REreq === 1'b1 && req_prev === 1'b0) rises++;
            req_prev = bus.REreq;
            if (bus.ovf === 1'b1) ovf_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_done", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_done_seq", 32'(done_cnt), 32'(e));
                end
            end
        end
    end

    initial begin : stimulus
        int r0, d0, o0;
        vectors     = 0;
        miscompares = 0;
        rises       = 0;
        done_cnt    = 0;
        ovf_cnt     = 0;
        sb_next_id  = 0;
        ctrl_en     = 1'b1;
        bus.start   = 1'b0;
        bus.REack   = 1'b0;
        rst         = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_REreq",    32'(bus.REreq),    32'd0);
        check("rst_busy",     32'(bus.busy),     32'd0);
        check("rst_done",     32'(bus.done),     32'd0);
        check("rst_ovf",      32'(bus.ovf),      32'd0);
        check("rst_timeout",  32'(bus.timeout),  32'd0);
        check("rst_pend_cnt", 32'(bus.pend_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // ---------------- single transaction ----------------
        r0 = rises; d0 = done_cnt;
        push_expected(1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("single_req_rise", 32'(bus.REreq),    32'd1);
        check("single_pend",     32'(bus.pend_cnt), 32'd0);
        check("single_busy",     32'(bus.busy),     32'd1);
        wait_ack(1'b1, "single_ack_rise_seen");
        tick();
        check("single_req_hold", 32'(bus.REreq), 32'd1);
        tick();
        check("single_req_fall", 32'(bus.REreq), 32'd0);
        wait_ack(1'b0, "single_ack_fall_seen");
        tick();
        check("single_no_early_done", 32'(bus.done), 32'd0);
        tick();
        check("single_done",      32'(bus.done),  32'd1);
        check("single_req_low",   32'(bus.REreq), 32'd0);
        tick();
        check("single_done_end",  32'(bus.done),     32'd0);
        check("single_busy_end",  32'(bus.busy),     32'd0);
        check("single_pend_end",  32'(bus.pend_cnt), 32'd0);
        check("single_rise_count", 32'(rises - r0),    32'd1);
        check("single_done_count", 32'(done_cnt - d0), 32'd1);
        repeat (4) tick();

        // ---------------- burst of five starts ----------------
        r0 = rises; d0 = done_cnt;
        push_expected(5);
        for (int i = 0; i < 5; i++) begin
            bus.start = 1'b1;
            tick();
            check("burst_pend_fill", 32'(bus.pend_cnt), 32'(i));
        end
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_done("burst_done_seen");
            check("burst_pend_drain", 32'(bus.pend_cnt), 32'((k < 4) ? (3 - k) : 0));
            check("burst_req_rerise", 32'(bus.REreq),    32'(k < 4));
        end
        tick();
        check("burst_rise_count", 32'(rises - r0),    32'd5);
        check("burst_done_count", 32'(done_cnt - d0), 32'd5);
        check("burst_busy_end",   32'(bus.busy),      32'd0);
        repeat (4) tick();

        // ---------------- saturation with stalled controller ----------------
        o0 = ovf_cnt; d0 = done_cnt;
        ctrl_en = 1'b0;
        push_expected(PEND_MAX + 1);
        for (int i = 0; i < PEND_MAX + 3; i++) begin
            bus.start = 1'b1;
            tick();
            check("sat_pend", 32'(bus.pend_cnt), 32'((i > PEND_MAX) ? PEND_MAX : i));
            check("sat_ovf",  32'(bus.ovf),      32'(i > PEND_MAX));
        end
        bus.start = 1'b0;
        tick();
        check("sat_ovf_clear", 32'(bus.ovf),      32'd0);
        check("sat_pend_hold", 32'(bus.pend_cnt), 32'(PEND_MAX));
        check("sat_req_high",  32'(bus.REreq),    32'd1);
        ctrl_en = 1'b1;
        for (int k = 0; k <= PEND_MAX; k++) begin
            wait_done("sat_done_seen");
        end
        tick();
        check("sat_ovf_count",  32'(ovf_cnt - o0),   32'd2);
        check("sat_done_count", 32'(done_cnt - d0),  32'(PEND_MAX + 1));
        check("sat_pend_end",   32'(bus.pend_cnt),   32'd0);
        check("sat_busy_end",   32'(bus.busy),       32'd0);
        repeat (4) tick();

        // ---------------- start coincident with done, queue empty ----------------
        push_expected(2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_ack(1'b1, "simul_ack_rise_seen");
        wait_ack(1'b0, "simul_ack_fall_seen");
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("simul_done",   32'(bus.done),     32'd1);
        check("simul_rerise", 32'(bus.REreq),    32'd1);
        check("simul_pend",   32'(bus.pend_cnt), 32'd0);
        wait_done("simul_second_done");
        tick();
        check("simul_req_end",  32'(bus.REreq), 32'd0);
        check("simul_busy_end", 32'(bus.busy),  32'd0);
        repeat (4) tick();

        // ---------------- reset in the middle of a handshake ----------------
        ctrl_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.start = 1'b1;
            tick();
        end
        bus.start = 1'b0;
        check("mid_pre_pend", 32'(bus.pend_cnt), 32'd2);
        check("mid_pre_req",  32'(bus.REreq),    32'd1);
        bus.REack = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_req",  32'(bus.REreq),    32'd0);
        check("mid_rst_pend", 32'(bus.pend_cnt), 32'd0);
        check("mid_rst_busy", 32'(bus.busy),     32'd0);
        repeat (3) tick();
        push_expected(1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("mid_held_req",  32'(bus.REreq),    32'd0);
        check("mid_held_pend", 32'(bus.pend_cnt), 32'd1);
        check("mid_held_busy", 32'(bus.busy),     32'd1);
        repeat (4) tick();
        check("mid_still_held", 32'(bus.REreq), 32'd0);
        bus.REack = 1'b0;
        tick();
        check("mid_sync_1", 32'(bus.REreq), 32'd0);
        tick();
        check("mid_sync_2", 32'(bus.REreq), 32'd0);
        tick();
        check("mid_rise",      32'(bus.REreq),    32'd1);
        check("mid_rise_pend", 32'(bus.pend_cnt), 32'd0);
        ctrl_en = 1'b1;
        wait_done("mid_done_seen");
        tick();
        check("mid_busy_end", 32'(bus.busy), 32'd0);
        repeat (4) tick();

        // ---------------- controller never acknowledges ----------------
        ctrl_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.start = 1'b1;
            tick();
        end
        bus.start = 1'b0;
        check("stall_req",  32'(bus.REreq),    32'd1);
        check("stall_pend", 32'(bus.pend_cnt), 32'd2);
`ifdef RE_REQUESTER_TIMEOUT_EN
        repeat (TO_CYCLES - 3) tick();
        check("to_not_yet",     32'(bus.timeout), 32'd0);
        check("to_req_before",  32'(bus.REreq),   32'd1);
        tick();
        check("to_pulse",       32'(bus.timeout),  32'd1);
        check("to_req_drop",    32'(bus.REreq),    32'd0);
        check("to_pend_flush",  32'(bus.pend_cnt), 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("to_pulse_end",   32'(bus.timeout),  32'd0);
        check("to_idle_busy",   32'(bus.busy),     32'd0);
        check("to_abort_drop",  32'(bus.pend_cnt), 32'd0);
        check("to_abort_noovf", 32'(bus.ovf),      32'd0);
        tick();
        check("to_idle_req",    32'(bus.REreq),    32'd0);
`else
        repeat (3 * TO_CYCLES) tick();
        check("noto_req_high", 32'(bus.REreq),    32'd1);
        check("noto_timeout",  32'(bus.timeout),  32'd0);
        check("noto_pend",     32'(bus.pend_cnt), 32'd2);
        check("noto_busy",     32'(bus.busy),     32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("noto_rst_req", 32'(bus.REreq), 32'd0);
`endif
        ctrl_en = 1'b1;
        repeat (4) tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
